// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART command-frame controllers.
package uart_ctrl_pkg;

    typedef enum logic [2:0] {
        WAIT_A_LO,
        WAIT_A_HI,
        WAIT_B_LO,
        WAIT_B_HI,
        WAIT_CMD
    } rx_state_t;

    localparam int RX_FRAME_BYTES = 5;

endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte timer: counts enabled cycles since the last clear and flags the last allowed cycle.
module uart_byte_timeout #(
    parameter int T = 5000000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(T) + 1;
    localparam logic [W-1:0] LAST = W'(T - 1);

    logic [W-1:0] count;

    // Clear wins over enable; expiry is acted on by the owner, so the count never passes LAST.
    always_ff @(posedge clock) begin
        if (reset)       count <= '0;
        else if (clear)  count <= '0;
        else if (enable) count <= count + W'(1);
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/uart_rx_control.sv
// Assembles A_lo, A_hi, B_lo, B_hi, CMD bytes into one frame and hands it to the ALU atomically.
module uart_rx_control
    import uart_ctrl_pkg::*;
#(
    parameter int INTER_BYTE_TIMEOUT = 5000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic [15:0] op_a,
    output logic [15:0] op_b,
    output logic [7:0]  op_cmd,
    output logic        trigger,
    output logic        timeout,
    output logic        busy
);

    rx_state_t state_q, state_d;
    logic      commit;
    logic      expired;
    logic      idle;
    logic [1:0] slot;
    logic [RX_FRAME_BYTES-2:0][7:0] shadow;

    assign idle = (state_q == WAIT_A_LO);
    assign busy = !idle;
    assign slot = state_q[1:0];

    uart_byte_timeout #(.T(INTER_BYTE_TIMEOUT)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (rx_ready || idle),
        .enable  (!idle && !rx_ready),
        .expired (expired)
    );

    // A byte arriving on the expiry cycle takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        if (rx_ready) begin
            case (state_q)
                WAIT_A_LO: state_d = WAIT_A_HI;
                WAIT_A_HI: state_d = WAIT_B_LO;
                WAIT_B_LO: state_d = WAIT_B_HI;
                WAIT_B_HI: state_d = WAIT_CMD;
                WAIT_CMD: begin
                    state_d = WAIT_A_LO;
                    commit  = 1'b1;
                end
                default:   state_d = WAIT_A_LO;
            endcase
        end else if (expired) begin
            state_d = WAIT_A_LO;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= WAIT_A_LO;
            shadow  <= '0;
            op_a    <= '0;
            op_b    <= '0;
            op_cmd  <= '0;
            trigger <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            trigger <= commit;
            timeout <= expired;
            if (rx_ready && state_q != WAIT_CMD)
                shadow[slot] <= rx_data;
            if (commit) begin
                op_a   <= {shadow[1], shadow[0]};
                op_b   <= {shadow[3], shadow[2]};
                op_cmd <= rx_data;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_control.sv
// Scoreboard bench for uart_rx_control with a short inter-byte timeout.
module tb_uart_rx_control;

    localparam int T = 16;

    logic        clock;
    logic        reset;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [7:0]  op_cmd;
    logic        trigger;
    logic        timeout;
    logic        busy;

    uart_rx_control #(.INTER_BYTE_TIMEOUT(T)) dut (
        .clock    (clock),
        .reset    (reset),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_cmd   (op_cmd),
        .trigger  (trigger),
        .timeout  (timeout),
        .busy     (busy)
    );

    typedef struct {
        bit          is_trig;
        int          cyc;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  c;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [15:0] ha = '0, hb = '0;
    logic [7:0]  hc = '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every trigger/timeout pulse must match the next queued expectation.
    always @(negedge clock) begin
        if (!reset) begin
            if (trigger && timeout) chk("trig_and_timeout", 1, 0);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                chk(q[0].is_trig ? "missed_trigger" : "missed_timeout", 0, 1);
                void'(q.pop_front());
            end
            if (trigger || timeout) begin
                if (q.size() == 0) begin
                    chk(trigger ? "unexpected_trigger" : "unexpected_timeout", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("pulse_kind", {31'b0, trigger}, {31'b0, e.is_trig});
                    chk("pulse_cycle", cyc, e.cyc);
                    chk("op_a", op_a, e.a);
                    chk("op_b", op_b, e.b);
                    chk("op_cmd", op_cmd, e.c);
                    chk("busy_at_pulse", busy, 0);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, output int c);
        c = cyc;
        rx_ready = 1'b1;
        rx_data  = d;
        @(posedge clock);
        #1;
        rx_ready = 1'b0;
    endtask

    task automatic push_trig(input int c, input logic [15:0] a, input logic [15:0] b,
                             input logic [7:0] cmd);
        exp_t e;
        e = '{1'b1, c + 1, a, b, cmd};
        q.push_back(e);
        ha = a; hb = b; hc = cmd;
    endtask

    task automatic push_tmo(input int c);
        exp_t e;
        e = '{1'b0, c + T + 1, ha, hb, hc};
        q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4, input int gap,
                              input logic [15:0] ea, input logic [15:0] eb, input logic [7:0] ec);
        int c;
        send_byte(b0, c); idle(gap - 1);
        send_byte(b1, c); idle(gap - 1);
        send_byte(b2, c); idle(gap - 1);
        send_byte(b3, c); idle(gap - 1);
        push_trig(cyc, ea, eb, ec);
        send_byte(b4, c);
    endtask

    initial begin
        int c;
        reset    = 1'b1;
        rx_ready = 1'b0;
        rx_data  = '0;
        idle(3);
        reset = 1'b0;
        chk("reset_op_a", op_a, 0);
        chk("reset_op_b", op_b, 0);
        chk("reset_op_cmd", op_cmd, 0);
        chk("reset_trigger", trigger, 0);
        chk("reset_timeout", timeout, 0);
        chk("reset_busy", busy, 0);

        // Idle: nothing may happen without input
        for (int i = 0; i < 100; i++) begin
            if (i % 10 == 0) chk("idle_busy", busy, 0);
            idle(1);
        end

        // Full frame, 5-cycle spacing
        send_frame(8'h34, 8'h12, 8'h78, 8'h56, 8'h02, 5, 16'h1234, 16'h5678, 8'h02);
        idle(10);

        // Back-to-back frames, second starting in the trigger cycle
        send_frame(8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 1, 16'h0001, 16'h0002, 8'h00);
        send_frame(8'hFF, 8'hFF, 8'h01, 8'h00, 8'h01, 1, 16'hFFFF, 16'h0001, 8'h01);
        idle(5);

        // Timeout mid-frame, then a clean frame
        send_byte(8'h10, c);
        chk("busy_midframe", busy, 1);
        send_byte(8'h20, c);
        push_tmo(c);
        idle(20);
        chk("busy_after_timeout", busy, 0);
        send_frame(8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h03, 2, 16'hBBAA, 16'hDDCC, 8'h03);
        idle(5);

        // Byte exactly T cycles after the previous one is still accepted
        send_byte(8'h11, c);
        send_byte(8'h22, c);
        idle(T - 1);
        send_byte(8'h33, c);
        send_byte(8'h44, c);
        push_trig(cyc, 16'h2211, 16'h4433, 8'h05);
        send_byte(8'h05, c);
        idle(5);

        // Byte at T+1 cycles lands in the timeout cycle and starts a new frame
        send_byte(8'h55, c);
        send_byte(8'h66, c);
        push_tmo(c);
        idle(T);
        send_frame(8'h77, 8'h88, 8'h99, 8'hAA, 8'h06, 1, 16'h8877, 16'hAA99, 8'h06);
        idle(5);

        // Reset after four bytes drops the partial frame and clears outputs
        send_byte(8'h01, c); idle(1);
        send_byte(8'h02, c); idle(1);
        send_byte(8'h03, c); idle(1);
        send_byte(8'h04, c);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        ha = '0; hb = '0; hc = '0;
        chk("rst_mid_op_a", op_a, 0);
        chk("rst_mid_op_b", op_b, 0);
        chk("rst_mid_op_cmd", op_cmd, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_trigger", trigger, 0);
        send_frame(8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h07, 3, 16'hBEEF, 16'hDEAD, 8'h07);
        idle(30);

        chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_control.md
Name: uart_rx_control

Overview:
Receive-side counterpart of the UART transmit controller. Consumes bytes from the UART receive driver, one `rx_ready` pulse per byte. Assembles a 5-byte command frame: operand A (16 bit), operand B (16 bit), command byte. Presents the three fields atomically to the ALU datapath with a one-cycle `trigger` pulse. An inter-byte timeout discards partial frames so the host can resynchronise.

Parameters:
INTER_BYTE_TIMEOUT, 5000000, clock cycles allowed between consecutive bytes of one frame before the partial frame is discarded (must be >= 2)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
rx_ready  input  1  one-cycle pulse from UART RX driver; rx_data valid in same cycle
rx_data  input  8  received byte
op_a  output  16  operand A of last complete frame
op_b  output  16  operand B of last complete frame
op_cmd  output  8  command byte of last complete frame
trigger  output  1  one-cycle pulse: op_a/op_b/op_cmd just updated
timeout  output  1  one-cycle pulse: partial frame discarded
busy  output  1  high while a frame is partially received

Behaviour:
- One clock domain. `reset` is synchronous and active-high; it is sampled on the rising edge of `clock`.
- Reset values: state=WAIT_A_LO, op_a=0, op_b=0, op_cmd=0, trigger=0, timeout=0, busy=0, shadow regs=0, timer=0.
- Byte order on the wire is A_lo, A_hi, B_lo, B_hi, CMD. This matches the TX side, which sends the low byte first.
- States and transitions on rx_ready:
  - WAIT_A_LO -> WAIT_A_HI
  - WAIT_A_HI -> WAIT_B_LO
  - WAIT_B_LO -> WAIT_B_HI
  - WAIT_B_HI -> WAIT_CMD
  - WAIT_CMD -> WAIT_A_LO
- Each accepted byte is written to its shadow register slot at the edge ending the rx_ready cycle.
- Commit: if rx_ready=1 in cycle n while in WAIT_CMD, then at the end of cycle n op_a, op_b and op_cmd load the shadow values and rx_data together. trigger=1 in cycle n+1 only.
- Outputs never change except at commit or reset. A partial frame never disturbs op_a/op_b/op_cmd.
- busy = (state != WAIT_A_LO). It is combinational from the state register.
- Timer:
  - Cleared to 0 on every accepted byte.
  - Held at 0 in WAIT_A_LO.
  - Increments each cycle in the other states without rx_ready.
- Timeout rule:
  - Applies when the last accepted byte's rx_ready was in cycle n and there is no rx_ready in cycles n+1..n+T, where T = INTER_BYTE_TIMEOUT.
  - The timer reads T-1 in cycle n+T.
  - In cycle n+T+1: state=WAIT_A_LO and timeout=1 for exactly that cycle.
  - Shadow contents are don't-care after a timeout; outputs are unchanged.
- Simultaneous rx_ready and timer==T-1: the byte wins. It is accepted normally, the timer clears, and no timeout fires.
- rx_ready in the cycle where trigger or timeout is high: accepted as A_lo (state is already WAIT_A_LO).
- trigger and timeout are never high in the same cycle.
- Reset mid-frame: returns immediately to reset values; the partial frame is lost and trigger does not fire.
- Timer width: $clog2(INTER_BYTE_TIMEOUT)+1 bits; the timer never wraps.

Decomposition:
- Package uart_ctrl_pkg holds:
  - typedef enum logic [2:0] rx_state_t {WAIT_A_LO, WAIT_A_HI, WAIT_B_LO, WAIT_B_HI, WAIT_CMD}
  - localparam RX_FRAME_BYTES = 5
- One sub-module: uart_byte_timeout. It contains the parameterised counter with clear/enable inputs and a `expired` output (timer==T-1 and enable). It is reusable by the TX controller for its inter-byte delay.

Test Plan (T=16 overridden):
1. Full frame: bytes 0x34,0x12,0x78,0x56,0x02 spaced 5 cycles apart -> trigger pulse one cycle after the 5th rx_ready; op_a=0x1234, op_b=0x5678, op_cmd=0x02; busy low again in that cycle.
2. Back-to-back frames, second frame's first byte in the trigger cycle: frame 0x01,0x00,0x02,0x00,0x00 then 0xFF,0xFF,0x01,0x00,0x01 -> two triggers; final op_a=0xFFFF, op_b=0x0001, op_cmd=0x01.
3. Timeout mid-frame: 2 bytes, then silence -> timeout=1 exactly 17 cycles after the 2nd rx_ready; busy=0; outputs still hold the previous frame. A following full 5-byte frame commits correctly.
4. Boundary: 3rd byte arrives exactly 16 cycles after the 2nd -> accepted, no timeout; a byte arriving at 17 cycles instead -> timeout fires and that byte is taken as A_lo.
5. Reset mid-frame after 4 bytes -> next cycle all outputs 0 and busy=0; a following 5-byte frame commits with correct values and a single trigger.
6. Idle: no rx_ready for 100 cycles from reset -> timeout, trigger and busy stay 0.
